// File: rtl/coralnpu_cosim_seq_pkg.sv
// Shared types for the MPACT co-simulation retire sequencer.
// Provides the session state encoding, DPI command opcodes, sticky error
// codes, the DPI success status value and a small popcount helper used
// when several retirement lanes land in the buffer together.
package coralnpu_cosim_seq_pkg;

  // Session FSM states. The numeric values are visible on state_o.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_INIT   = 4'd1,
    ST_CONFIG = 4'd2,
    ST_LOAD   = 4'd3,
    ST_RESET  = 4'd4,
    ST_RUN    = 4'd5,
    ST_DRAIN  = 4'd6,
    ST_FINI   = 4'd7,
    ST_DONE   = 4'd8,
    ST_ERROR  = 4'd9
  } state_e;

  // Session commands handed to the DPI wrapper.
  typedef enum logic [2:0] {
    OP_INIT   = 3'd0,
    OP_CONFIG = 3'd1,
    OP_LOAD   = 3'd2,
    OP_RESET  = 3'd3,
    OP_FINI   = 3'd4
  } cmd_op_e;

  // First-error codes reported on err_code_o.
  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_CMD      = 3'd1,
    ERR_STEP     = 3'd2,
    ERR_OVERFLOW = 3'd3,
    ERR_HALT     = 3'd4
  } err_code_e;

  // DPI functions return zero on success.
  localparam logic [31:0] STATUS_OK = 32'd0;

  // Number of set bits in an up-to-8-lane valid vector.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/coralnpu_cosim_retire_fifo.sv
// Multi-write, single-read circular buffer for retired instructions.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   wr_en                 allow this cycle's valid lanes to be written
//   wr_valid/wr_pc/wr_insn  per-lane retirement data (lane 0 in low bits)
//   rd_en                 pop the head entry (caller guarantees non-empty)
//   rd_pc/rd_insn         head entry
//   count/count_next      current occupancy and occupancy after this cycle
module coralnpu_cosim_retire_fifo
  import coralnpu_cosim_seq_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [LANES-1:0]      wr_valid,
  input  logic [32*LANES-1:0]   wr_pc,
  input  logic [32*LANES-1:0]   wr_insn,
  input  logic                  rd_en,
  output logic [31:0]           rd_pc,
  output logic [31:0]           rd_insn,
  output logic [CW-1:0]         count,
  output logic [CW-1:0]         count_next
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   insn_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] slot [LANES];
  logic [3:0]    n_wr;

  // Compaction: each valid lane lands at wr_ptr plus the number of valid
  // lanes below it, so gaps in the valid vector never leave holes.
  always_comb begin
    logic [PW-1:0] off;
    off = '0;
    for (int i = 0; i < LANES; i++) begin
      slot[i] = wr_ptr + off;
      if (wr_valid[i]) off = off + PW'(1);
    end
  end

  assign n_wr       = wr_en ? popcount8(8'(wr_valid)) : 4'd0;
  assign count_next = count + CW'(n_wr) - CW'(rd_en);
  assign rd_pc      = pc_mem[rd_ptr];
  assign rd_insn    = insn_mem[rd_ptr];

  // Storage is not reset; the top only exposes the head while it is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_valid[i]) begin
          pc_mem[slot[i]]   <= wr_pc[32*i +: 32];
          insn_mem[slot[i]] <= wr_insn[32*i +: 32];
        end
      end
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(n_wr);
      rd_ptr <= rd_ptr + PW'(rd_en);
      count  <= count_next;
    end
  end

endmodule

// File: rtl/coralnpu_cosim_retire_sequencer.sv
// Orders the MPACT co-simulation session (init/config/load/reset, run,
// fini) and turns multi-lane DUT retirements into one-at-a-time step
// requests for the DPI wrapper, with buffering, flow control and
// error/halt detection.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   start_i, done_i               session begin / DUT finished pulses
//   retire_valid_i/pc_i/insn_i    retirement monitor lanes
//   retire_ready_o                room for a full set of lanes
//   cmd_req_o/cmd_op_o/cmd_ack_i/cmd_status_i   session command handshake
//   step_req_o/step_pc_o/step_insn_o/step_ack_i/step_status_i/halted_i
//                                 single-step handshake
//   state_o, step_count_o, error_o, err_code_o, done_o   status
module coralnpu_cosim_retire_sequencer
  import coralnpu_cosim_seq_pkg::*;
#(
  parameter int RETIRE_LANES = 4,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic                        done_i,
  input  logic [RETIRE_LANES-1:0]     retire_valid_i,
  input  logic [32*RETIRE_LANES-1:0]  retire_pc_i,
  input  logic [32*RETIRE_LANES-1:0]  retire_insn_i,
  output logic                        retire_ready_o,
  output logic                        cmd_req_o,
  output logic [2:0]                  cmd_op_o,
  input  logic                        cmd_ack_i,
  input  logic [31:0]                 cmd_status_i,
  output logic                        step_req_o,
  output logic [31:0]                 step_pc_o,
  output logic [31:0]                 step_insn_o,
  input  logic                        step_ack_i,
  input  logic [31:0]                 step_status_i,
  input  logic                        halted_i,
  output logic [3:0]                  state_o,
  output logic [31:0]                 step_count_o,
  output logic                        error_o,
  output logic [2:0]                  err_code_o,
  output logic                        done_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] MAX_FILL = CW'(FIFO_DEPTH - RETIRE_LANES);

  state_e        state;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [31:0]   head_pc;
  logic [31:0]   head_insn;
  logic          in_run;
  logic          overflow;
  logic          deq;

  function automatic cmd_op_e op_of(input state_e s);
    case (s)
      ST_INIT:   return OP_INIT;
      ST_CONFIG: return OP_CONFIG;
      ST_LOAD:   return OP_LOAD;
      ST_RESET:  return OP_RESET;
      default:   return OP_FINI;
    endcase
  endfunction

  function automatic state_e after_cmd(input state_e s);
    case (s)
      ST_INIT:   return ST_CONFIG;
      ST_CONFIG: return ST_LOAD;
      ST_LOAD:   return ST_RESET;
      ST_RESET:  return ST_RUN;
      default:   return ST_DONE;
    endcase
  endfunction

  // Flow control and step handshake derive only from registered state, so
  // an entry written this cycle shows up as a step request next cycle.
  assign in_run         = (state == ST_RUN) || (state == ST_DRAIN);
  assign retire_ready_o = in_run && (count <= MAX_FILL);
  assign overflow       = in_run && (|retire_valid_i) && !retire_ready_o;
  assign step_req_o     = in_run && (count != '0);
  assign deq            = step_req_o && step_ack_i;
  assign step_pc_o      = step_req_o ? head_pc   : 32'd0;
  assign step_insn_o    = step_req_o ? head_insn : 32'd0;
  assign state_o        = state;

  coralnpu_cosim_retire_fifo #(
    .LANES (RETIRE_LANES),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (retire_ready_o),
    .wr_valid   (retire_valid_i),
    .wr_pc      (retire_pc_i),
    .wr_insn    (retire_insn_i),
    .rd_en      (deq),
    .rd_pc      (head_pc),
    .rd_insn    (head_insn),
    .count      (count),
    .count_next (count_next)
  );

  // Session FSM. Command states drop cmd_req_o for one cycle on entry, then
  // hold it with a stable opcode until acked. In RUN/DRAIN the first error
  // wins: step failure, then overflow, then a halt with work still queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cmd_req_o    <= 1'b0;
      cmd_op_o     <= OP_INIT;
      step_count_o <= 32'd0;
      error_o      <= 1'b0;
      err_code_o   <= ERR_NONE;
      done_o       <= 1'b0;
    end else begin
      if (deq) step_count_o <= step_count_o + 32'd1;
      case (state)
        ST_IDLE: begin
          if (start_i) state <= ST_INIT;
        end
        ST_INIT, ST_CONFIG, ST_LOAD, ST_RESET, ST_FINI: begin
          if (!cmd_req_o) begin
            cmd_req_o <= 1'b1;
            cmd_op_o  <= op_of(state);
          end else if (cmd_ack_i) begin
            cmd_req_o <= 1'b0;
            if (cmd_status_i != STATUS_OK) begin
              state      <= ST_ERROR;
              error_o    <= 1'b1;
              err_code_o <= ERR_CMD;
            end else begin
              state <= after_cmd(state);
              if (state == ST_FINI) done_o <= 1'b1;
            end
          end
        end
        ST_RUN, ST_DRAIN: begin
          if (deq && (step_status_i != STATUS_OK)) begin
            state      <= ST_ERROR;
            error_o    <= 1'b1;
            err_code_o <= ERR_STEP;
          end else if (overflow) begin
            state      <= ST_ERROR;
            error_o    <= 1'b1;
            err_code_o <= ERR_OVERFLOW;
          end else if (deq && halted_i && (count_next != '0)) begin
            state      <= ST_ERROR;
            error_o    <= 1'b1;
            err_code_o <= ERR_HALT;
          end else if (deq && halted_i) begin
            state <= ST_DRAIN;
          end else if ((state == ST_RUN) && done_i) begin
            state <= ST_DRAIN;
          end else if ((state == ST_DRAIN) && (count == '0) && !(|retire_valid_i)) begin
            state <= ST_FINI;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coralnpu_cosim_retire_sequencer.sv
// Self-checking bench for coralnpu_cosim_retire_sequencer. A queue of
// expected retirements plus a step counter predicts the step handshake;
// session sequencing and error outcomes are checked against fixed values.
module tb_coralnpu_cosim_retire_sequencer;

  localparam int LANES = 4;
  localparam int DEPTH = 16;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
  } entry_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start_i, done_i;
  logic [LANES-1:0]     retire_valid_i;
  logic [32*LANES-1:0]  retire_pc_i, retire_insn_i;
  logic                 retire_ready_o;
  logic                 cmd_req_o;
  logic [2:0]           cmd_op_o;
  logic                 cmd_ack_i;
  logic [31:0]          cmd_status_i;
  logic                 step_req_o;
  logic [31:0]          step_pc_o, step_insn_o;
  logic                 step_ack_i;
  logic [31:0]          step_status_i;
  logic                 halted_i;
  logic [3:0]           state_o;
  logic [31:0]          step_count_o;
  logic                 error_o;
  logic [2:0]           err_code_o;
  logic                 done_o;

  int     tests = 0;
  int     failures = 0;
  entry_t model_q[$];
  int     model_steps = 0;

  coralnpu_cosim_retire_sequencer #(
    .RETIRE_LANES (LANES),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .done_i         (done_i),
    .retire_valid_i (retire_valid_i),
    .retire_pc_i    (retire_pc_i),
    .retire_insn_i  (retire_insn_i),
    .retire_ready_o (retire_ready_o),
    .cmd_req_o      (cmd_req_o),
    .cmd_op_o       (cmd_op_o),
    .cmd_ack_i      (cmd_ack_i),
    .cmd_status_i   (cmd_status_i),
    .step_req_o     (step_req_o),
    .step_pc_o      (step_pc_o),
    .step_insn_o    (step_insn_o),
    .step_ack_i     (step_ack_i),
    .step_status_i  (step_status_i),
    .halted_i       (halted_i),
    .state_o        (state_o),
    .step_count_o   (step_count_o),
    .error_o        (error_o),
    .err_code_o     (err_code_o),
    .done_o         (done_o)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Hard stop in case a handshake never completes
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point; every check in the bench goes through here
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit modelReady();
    return model_q.size() <= (DEPTH - LANES);
  endfunction

  task automatic clearInputs();
    start_i = 0; done_i = 0; retire_valid_i = '0; retire_pc_i = '0;
    retire_insn_i = '0; cmd_ack_i = 0; cmd_status_i = '0; step_ack_i = 0;
    step_status_i = '0; halted_i = 0;
  endtask

  task automatic doReset();
    rst = 1;
    clearInputs();
    model_q.delete();
    model_steps = 0;
    repeat (2) tick();
    rst = 0;
    tick();
  endtask

  // One RUN/DRAIN cycle: compare the step side against the model, drive a
  // set of retirements and an optional step ack, then update the model
  task automatic applyStimulus(input logic [LANES-1:0] v, input logic [32*LANES-1:0] pcs,
                               input logic ack, input logic [31:0] status,
                               input logic halt);
    logic [32*LANES-1:0] insns;
    bit accept;
    for (int i = 0; i < LANES; i++) insns[32*i +: 32] = $urandom;
    checkOutput("retire_ready", 32'(retire_ready_o), 32'(modelReady()));
    checkOutput("step_req", 32'(step_req_o), 32'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      checkOutput("step_pc", step_pc_o, model_q[0].pc);
      checkOutput("step_insn", step_insn_o, model_q[0].insn);
    end
    checkOutput("step_count", step_count_o, 32'(model_steps));
    accept = modelReady();
    retire_valid_i = v;
    retire_pc_i = pcs;
    retire_insn_i = insns;
    step_ack_i = ack;
    step_status_i = status;
    halted_i = halt;
    tick();
    if (ack && model_q.size() != 0) begin
      void'(model_q.pop_front());
      model_steps++;
    end
    if (accept) begin
      for (int i = 0; i < LANES; i++) begin
        if (v[i]) model_q.push_back('{pc: pcs[32*i +: 32], insn: insns[32*i +: 32]});
      end
    end
    retire_valid_i = '0;
    step_ack_i = 0;
    step_status_i = '0;
    halted_i = 0;
  endtask

  // Wait (bounded) for a command request, check its opcode, ack it with the
  // given status and confirm the request drops straight after
  task automatic waitCmd(input logic [2:0] op, input logic [31:0] status);
    int n = 0;
    while (!cmd_req_o && n < 20) begin
      tick();
      n++;
    end
    checkOutput("cmd_req_rise", 32'(cmd_req_o), 32'd1);
    checkOutput("cmd_op", 32'(cmd_op_o), 32'(op));
    cmd_ack_i = 1;
    cmd_status_i = status;
    tick();
    cmd_ack_i = 0;
    cmd_status_i = '0;
    checkOutput("cmd_req_gap", 32'(cmd_req_o), 32'd0);
  endtask

  task automatic bringUp();
    start_i = 1;
    tick();
    start_i = 0;
    for (int op = 0; op < 4; op++) waitCmd(3'(op), 32'd0);
    checkOutput("state_run", 32'(state_o), 32'd5);
  endtask

  function automatic logic [32*LANES-1:0] randomPcs();
    logic [32*LANES-1:0] p;
    for (int i = 0; i < LANES; i++) p[32*i +: 32] = $urandom & 32'hFFFF_FFFC;
    return p;
  endfunction

  initial begin
    logic [32*LANES-1:0] pcs;
    logic [LANES-1:0] v;
    int guard;

    // Reset values while reset is held
    rst = 1;
    clearInputs();
    repeat (2) tick();
    checkOutput("rst_state", 32'(state_o), 32'd0);
    checkOutput("rst_cmd_req", 32'(cmd_req_o), 32'd0);
    checkOutput("rst_cmd_op", 32'(cmd_op_o), 32'd0);
    checkOutput("rst_step_req", 32'(step_req_o), 32'd0);
    checkOutput("rst_step_pc", step_pc_o, 32'd0);
    checkOutput("rst_step_insn", step_insn_o, 32'd0);
    checkOutput("rst_ready", 32'(retire_ready_o), 32'd0);
    checkOutput("rst_step_count", step_count_o, 32'd0);
    checkOutput("rst_error", 32'(error_o), 32'd0);
    checkOutput("rst_err_code", 32'(err_code_o), 32'd0);
    checkOutput("rst_done", 32'(done_o), 32'd0);
    rst = 0;
    tick();

    // Stray acks and retirements in IDLE change nothing
    cmd_ack_i = 1; step_ack_i = 1; retire_valid_i = '1;
    tick();
    clearInputs();
    checkOutput("idle_stray_state", 32'(state_o), 32'd0);
    checkOutput("idle_stray_count", step_count_o, 32'd0);
    checkOutput("idle_stray_step_req", 32'(step_req_o), 32'd0);

    // Session A: bring-up, directed lanes, random traffic, halt-on-empty close
    bringUp();
    pcs = {32'h84, 32'hDEAD_0000, 32'h80, 32'hDEAD_0004};
    applyStimulus(4'b1010, pcs, 0, 0, 0);
    checkOutput("dir_first_pc", step_pc_o, 32'h80);
    applyStimulus('0, pcs, 1, 0, 0);
    checkOutput("dir_second_pc", step_pc_o, 32'h84);
    applyStimulus('0, pcs, 1, 0, 0);
    checkOutput("dir_step_count", step_count_o, 32'd2);
    checkOutput("dir_idle_req", 32'(step_req_o), 32'd0);

    for (int c = 0; c < 300; c++) begin
      v = modelReady() ? LANES'($urandom) : '0;
      applyStimulus(v, randomPcs(), 1'($urandom_range(0, 1)), 0, 0);
    end
    guard = 0;
    while (model_q.size() != 0 && guard < 40) begin
      applyStimulus('0, '0, 1, 0, 0);
      guard++;
    end
    checkOutput("drain_empty", 32'(model_q.size()), 32'd0);

    applyStimulus(4'b0001, randomPcs(), 0, 0, 0);
    applyStimulus('0, '0, 1, 0, 1);
    checkOutput("halt_empty_drain", 32'(state_o), 32'd6);
    waitCmd(3'd4, 32'd0);
    checkOutput("halt_done_state", 32'(state_o), 32'd8);
    checkOutput("halt_done_flag", 32'(done_o), 32'd1);
    checkOutput("halt_done_error", 32'(error_o), 32'd0);

    // Session B: halt with entries still queued
    doReset();
    bringUp();
    applyStimulus(4'b0111, randomPcs(), 0, 0, 0);
    applyStimulus('0, '0, 1, 0, 1);
    checkOutput("halt_busy_state", 32'(state_o), 32'd9);
    checkOutput("halt_busy_error", 32'(error_o), 32'd1);
    checkOutput("halt_busy_code", 32'(err_code_o), 32'd4);
    checkOutput("halt_busy_step_req", 32'(step_req_o), 32'd0);

    // Session C: fill the buffer, then retire once more
    doReset();
    bringUp();
    for (int k = 0; k < 4; k++) applyStimulus(4'b1111, randomPcs(), 0, 0, 0);
    applyStimulus(4'b0001, randomPcs(), 0, 0, 0);
    checkOutput("ovf_state", 32'(state_o), 32'd9);
    checkOutput("ovf_error", 32'(error_o), 32'd1);
    checkOutput("ovf_code", 32'(err_code_o), 32'd3);

    // Session D: step failure stops stepping
    doReset();
    bringUp();
    applyStimulus(4'b0011, randomPcs(), 0, 0, 0);
    applyStimulus('0, '0, 1, 32'd1, 0);
    checkOutput("stepfail_state", 32'(state_o), 32'd9);
    checkOutput("stepfail_code", 32'(err_code_o), 32'd2);
    for (int k = 0; k < 3; k++) begin
      checkOutput("stepfail_no_req", 32'(step_req_o), 32'd0);
      tick();
    end

    // Session E: reset mid-run with 5 queued, then close via done_i
    doReset();
    bringUp();
    applyStimulus(4'b1111, randomPcs(), 0, 0, 0);
    applyStimulus(4'b0011, randomPcs(), 0, 0, 0);
    applyStimulus('0, '0, 1, 0, 0);
    checkOutput("pre_rst_count", step_count_o, 32'd1);
    #2;
    rst = 1;
    #1;
    checkOutput("midrst_state", 32'(state_o), 32'd0);
    checkOutput("midrst_step_req", 32'(step_req_o), 32'd0);
    checkOutput("midrst_step_pc", step_pc_o, 32'd0);
    checkOutput("midrst_ready", 32'(retire_ready_o), 32'd0);
    checkOutput("midrst_count", step_count_o, 32'd0);
    checkOutput("midrst_cmd_req", 32'(cmd_req_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 0;
    model_q.delete();
    model_steps = 0;
    tick();
    bringUp();
    applyStimulus('0, '0, 0, 0, 0);
    done_i = 1;
    tick();
    done_i = 0;
    checkOutput("done_drain", 32'(state_o), 32'd6);
    waitCmd(3'd4, 32'd0);
    checkOutput("done_state", 32'(state_o), 32'd8);
    checkOutput("done_flag", 32'(done_o), 32'd1);

    // Session F: failed session command
    doReset();
    start_i = 1;
    tick();
    start_i = 0;
    waitCmd(3'd0, 32'd7);
    checkOutput("cmdfail_state", 32'(state_o), 32'd9);
    checkOutput("cmdfail_code", 32'(err_code_o), 32'd1);
    checkOutput("cmdfail_error", 32'(error_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/coralnpu_cosim_retire_sequencer.md
# coralnpu_cosim_retire_sequencer

Sequences the MPACT co-simulation session and serialises DUT instruction retirements into single-instruction step requests. Sits in the UVM co-simulation environment, between the RTL retirement monitor (up to RETIRE_LANES retirements per cycle) and the DPI wrapper that calls the MPACT init/config/load/reset/step/fini functions. Owns session ordering, retirement buffering, step flow control and error/halt detection.

## Interface
- RETIRE_LANES, 4, retirement lanes sampled per cycle (1..8)
- FIFO_DEPTH, 16, retirement buffer entries (power of two, >= 2*RETIRE_LANES)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start_i  in  1  pulse: begin session
- done_i  in  1  pulse: DUT finished, drain and close
- retire_valid_i  in  RETIRE_LANES  per-lane retire valid
- retire_pc_i  in  32*RETIRE_LANES  per-lane PC, lane 0 in bits [31:0]
- retire_insn_i  in  32*RETIRE_LANES  per-lane instruction word
- retire_ready_o  out  1  free entries >= RETIRE_LANES
- cmd_req_o  out  1  session command request
- cmd_op_o  out  3  0 INIT, 1 CONFIG, 2 LOAD, 3 RESET, 4 FINI
- cmd_ack_i  in  1  command complete
- cmd_status_i  in  32  DPI return value, 0 = success
- step_req_o  out  1  step request
- step_pc_o  out  32  PC of head entry
- step_insn_o  out  32  instruction of head entry
- step_ack_i  in  1  step complete
- step_status_i  in  32  step return value, 0 = success
- halted_i  in  1  simulator halt flag, valid with step_ack_i
- state_o  out  4  FSM state encoding
- step_count_o  out  32  completed steps
- error_o  out  1  sticky error
- err_code_o  out  3  0 none, 1 cmd fail, 2 step fail, 3 overflow, 4 retire-after-halt
- done_o  out  1  session closed

## Operation
- States: IDLE, INIT, CONFIG, LOAD, RESET, RUN, DRAIN, FINI, DONE, ERROR.
- IDLE -> INIT on start_i. INIT/CONFIG/LOAD/RESET/FINI each drive cmd_req_o with matching cmd_op_o until cmd_ack_i; nonzero cmd_status_i -> ERROR (code 1); otherwise advance INIT->CONFIG->LOAD->RESET->RUN, FINI->DONE.
- Enqueue (RUN, DRAIN only): valid lanes compacted in ascending lane order, written to consecutive FIFO slots in one cycle; count += popcount(retire_valid_i). Retirements outside RUN/DRAIN ignored.
- Any retire_valid_i bit while retire_ready_o low -> nothing written, ERROR (code 3).
- Step: in RUN/DRAIN, step_req_o high while FIFO non-empty; head dequeued and step_count_o incremented on step_ack_i. Nonzero step_status_i -> ERROR (code 2).
- Halt: step_ack_i with halted_i and FIFO still holding entries after the dequeue -> ERROR (code 4); with FIFO empty -> DRAIN.
- done_i in RUN -> DRAIN. DRAIN -> FINI when FIFO empty and no step outstanding.
- ERROR and DONE are terminal until rst; error_o/err_code_o hold first error only.
- Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH+1); simultaneous enqueue and dequeue: count += popcount − 1.

## Timing
- Reset: state IDLE, all req outputs 0, cmd_op_o 0, step_pc_o/step_insn_o 0, retire_ready_o 0, step_count_o 0, error_o 0, err_code_o 0, done_o 0, FIFO empty.
- retire_ready_o registered-free: combinational from count and state; high only in RUN/DRAIN.
- Enqueued entry visible on step_* the next cycle (1-cycle latency from retire to step_req_o when empty).
- Request held stable until ack; ack sampled only while req high; stray acks ignored. After an ack, next req rises no earlier than the following cycle (req low ≥1 cycle between commands; back-to-back steps allowed with req held high and new head data).
- One step outstanding max. rst mid-operation aborts immediately, FIFO discarded.

## Structure
- Package coralnpu_cosim_seq_pkg: state enum, cmd_op enum, err_code enum, status-OK constant.
- Sub-module coralnpu_cosim_retire_fifo: multi-write (RETIRE_LANES), single-read circular buffer with compaction; FSM in the top.

## Test plan
- Session bring-up: start_i, ack each cmd with status 0 -> cmd_op_o sequence 0,1,2,3, state RUN after 4 acks.
- Lanes 0b1010 with PCs 0x80,0x84 -> steps issued PC 0x80 then 0x84, step_count_o = 2.
- Fill 16 entries with step_ack_i withheld, then retire_valid_i = 0b0001 -> error_o, err_code_o = 3.
- Step ack with step_status_i = 1 -> ERROR, err_code_o = 2, no further step_req_o.
- halted_i on ack with 2 entries remaining -> err_code_o = 4; with 0 remaining -> DRAIN, FINI, DONE, done_o = 1.
- rst asserted mid-RUN with 5 queued -> all outputs reset values same cycle, FIFO empty.
